// File: rtl/cmd_parser.sv
// cmd_parser: framed command parser holding the sig_gen waveform configuration.
// Packets are SYNC, OPC, PHI, PLO, CHK where CHK = OPC ^ PHI ^ PLO.
// Latency: register writes, cfg_update and pkt_err appear 1 cycle after CHK is accepted.
// Backpressure: none; every rx_valid strobe is consumed in the cycle it arrives.
// Ports: clk/rst (sync, active-high), rx_data/rx_valid byte input,
//        state/state_freq/state_amp/state_phase config outputs,
//        cfg_update/pkt_err single-cycle pulses, err_cnt saturating error count.
module cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [4:0]  DEF_STATE   = 5'd0,
  parameter logic [11:0] DEF_FREQ    = 12'd1,
  parameter logic [2:0]  DEF_AMP     = 3'd7,
  parameter logic [7:0]  DEF_PHASE   = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [4:0]  state,
  output logic [11:0] state_freq,
  output logic [2:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic        cfg_update,
  output logic        pkt_err,
  output logic [7:0]  err_cnt
);

  // Counter only has to reach TIMEOUT_CYC-1.
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_OPC,
    GET_PHI,
    GET_PLO,
    GET_CHK
  } fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [TW-1:0] tcnt;
  logic [7:0]    opc_q, phi_q, plo_q;
  logic          wr_en, err_en, tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    wr_en  = 1'b0;
    err_en = 1'b0;
    tmo    = 1'b0;
    if (rx_valid) begin
      // A byte arriving on the terminal-count cycle takes priority over the timeout.
      unique case (fsm_q)
        IDLE:    if (rx_data == SYNC_BYTE) fsm_d = GET_OPC;
        GET_OPC: fsm_d = GET_PHI;
        GET_PHI: fsm_d = GET_PLO;
        GET_PLO: fsm_d = GET_CHK;
        GET_CHK: begin
          fsm_d = IDLE;
          if (rx_data != (opc_q ^ phi_q ^ plo_q)) begin
            err_en = 1'b1;
          end else if (opc_q == 8'h01 || opc_q == 8'h02 || opc_q == 8'h03 ||
                       opc_q == 8'h04 || opc_q == 8'h0F) begin
            wr_en = 1'b1;
          end else begin
            err_en = 1'b1;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end else if (fsm_q != IDLE && tcnt == TERM) begin
      fsm_d  = IDLE;
      err_en = 1'b1;
      tmo    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt        <= '0;
      opc_q       <= 8'h00;
      phi_q       <= 8'h00;
      plo_q       <= 8'h00;
      state       <= DEF_STATE;
      state_freq  <= DEF_FREQ;
      state_amp   <= DEF_AMP;
      state_phase <= DEF_PHASE;
      cfg_update  <= 1'b0;
      pkt_err     <= 1'b0;
      err_cnt     <= 8'h00;
    end else begin
      if (rx_valid || fsm_q == IDLE || tmo) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      if (rx_valid) begin
        if (fsm_q == GET_OPC) opc_q <= rx_data;
        if (fsm_q == GET_PHI) phi_q <= rx_data;
        if (fsm_q == GET_PLO) plo_q <= rx_data;
      end

      cfg_update <= wr_en;
      pkt_err    <= err_en;

      if (err_en && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (wr_en) begin
        case (opc_q)
          8'h01: state       <= plo_q[4:0];
          8'h02: state_freq  <= {phi_q[3:0], plo_q};
          8'h03: state_amp   <= plo_q[2:0];
          8'h04: state_phase <= plo_q;
          8'h0F: begin
            state       <= DEF_STATE;
            state_freq  <= DEF_FREQ;
            state_amp   <= DEF_AMP;
            state_phase <= DEF_PHASE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser: randomized and directed stimulus for cmd_parser with a
// packet-level reference model feeding a scoreboard queue; a monitor pops
// one expectation per cfg_update/pkt_err pulse and compares registers.
module tb_cmd_parser;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [4:0]  state;
  logic [11:0] state_freq;
  logic [2:0]  state_amp;
  logic [7:0]  state_phase;
  logic        cfg_update;
  logic        pkt_err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  cmd_parser #(.TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .state      (state),
    .state_freq (state_freq),
    .state_amp  (state_amp),
    .state_phase(state_phase),
    .cfg_update (cfg_update),
    .pkt_err    (pkt_err),
    .err_cnt    (err_cnt)
  );

  typedef struct packed {
    logic        err;
    logic [4:0]  st;
    logic [11:0] fr;
    logic [2:0]  am;
    logic [7:0]  ph;
    logic [7:0]  ec;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: registers plus the bytes collected for the packet in progress.
  logic [4:0]  m_st;
  logic [11:0] m_fr;
  logic [2:0]  m_am;
  logic [7:0]  m_ph;
  int          m_ec;
  logic [7:0]  m_buf[5];
  int          m_pos;
  int          idle_since;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h", name, act, req);
    else n_pass++;
  endtask

  function automatic exp_t snap(input logic err);
    exp_t e;
    e.err = err; e.st = m_st; e.fr = m_fr; e.am = m_am; e.ph = m_ph;
    e.ec = 8'(m_ec);
    return e;
  endfunction

  function automatic void model_defaults();
    m_st = 5'd0; m_fr = 12'd1; m_am = 3'd7; m_ph = 8'd0;
  endfunction

  function automatic void model_error();
    if (m_ec < 255) m_ec++;
    exp_q.push_back(snap(1'b1));
  endfunction

  function automatic void model_eval();
    logic [7:0] opc, phi, plo;
    opc = m_buf[1]; phi = m_buf[2]; plo = m_buf[3];
    if (m_buf[4] != (opc ^ phi ^ plo)) begin
      model_error();
      return;
    end
    case (opc)
      8'h01: m_st = plo[4:0];
      8'h02: m_fr = {phi[3:0], plo};
      8'h03: m_am = plo[2:0];
      8'h04: m_ph = plo;
      8'h0F: model_defaults();
      default: begin
        model_error();
        return;
      end
    endcase
    exp_q.push_back(snap(1'b0));
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_pos == 0) begin
      if (b == 8'hA5) begin
        m_buf[0] = b;
        m_pos = 1;
      end
    end else begin
      m_buf[m_pos] = b;
      m_pos++;
      if (m_pos == 5) begin
        model_eval();
        m_pos = 0;
      end
    end
  endfunction

  // One idle cycle; a packet left waiting TMO idle cycles is abandoned with an error.
  task automatic idle_cycle();
    idle_since++;
    if (m_pos > 0 && idle_since >= TMO) begin
      model_error();
      m_pos = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) idle_cycle();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) idle_cycle();
    model_byte(b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    idle_since = 0;
  endtask

  task automatic send_pkt(input logic [7:0] opc, input logic [7:0] phi,
                          input logic [7:0] plo, input logic [7:0] chk, input int gap);
    send_byte(8'hA5, gap);
    send_byte(opc, gap);
    send_byte(phi, gap);
    send_byte(plo, gap);
    send_byte(chk, gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    exp_q.delete();
    model_defaults();
    m_ec = 0; m_pos = 0; idle_since = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_regs(input string name);
    check(name, {state, state_freq, state_amp, state_phase, err_cnt},
          {m_st, m_fr, m_am, m_ph, 8'(m_ec)});
  endtask

  // Monitor: one scoreboard pop per output pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (cfg_update || pkt_err)) begin
        check("pulse_exclusive", {63'd0, cfg_update & pkt_err}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {62'd0, cfg_update, pkt_err}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check(e.err ? "err_pulse" : "update_pulse",
                {27'd0, pkt_err, state, state_freq, state_amp, state_phase, err_cnt},
                {27'd0, e});
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin
    int r, g;
    logic [7:0] opc, phi, plo, chk;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    model_defaults(); m_ec = 0; m_pos = 0; idle_since = 0;
    do_reset();
    @(negedge clk);
    check_regs("reset_regs");
    check("reset_pulses", {62'd0, cfg_update, pkt_err}, 64'd0);

    // Frequency write
    send_pkt(8'h02, 8'h0B, 8'hB8, 8'hB1, 0);
    idle(2); check_regs("freq_write");
    check("freq_value", {52'd0, state_freq}, 64'hBB8);

    // Amplitude then phase with 1-cycle gaps
    send_pkt(8'h03, 8'h00, 8'h05, 8'h03 ^ 8'h05, 1);
    send_pkt(8'h04, 8'h00, 8'h5A, 8'h5E, 1);
    idle(2); check_regs("amp_phase");
    check("amp_value", {61'd0, state_amp}, 64'd5);
    check("phase_value", {56'd0, state_phase}, 64'h5A);

    // Bad checksum, then bad opcode
    send_pkt(8'h01, 8'h00, 8'h03, 8'h00, 0);
    send_pkt(8'h07, 8'h00, 8'h00, 8'h07, 0);
    idle(2); check("err_cnt_two", {56'd0, err_cnt}, 64'd2);

    // Timeout after A5 01, then recovery
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    idle(TMO + 2);
    send_pkt(8'h01, 8'h00, 8'h02, 8'h03, 0);
    idle(2); check_regs("after_timeout");
    check("state_two", {59'd0, state}, 64'd2);

    // Byte arriving exactly on the terminal count is accepted
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, TMO - 1);
    send_byte(8'h04, TMO - 1); send_byte(8'h05, TMO - 1);
    idle(2); check_regs("terminal_count");

    // Junk in IDLE
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h13, 0);
    idle(3); check_regs("junk_idle");

    // Reset between PHI and PLO
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h03, 0);
    idle(3); check_regs("reset_mid_packet");
    send_pkt(8'h03, 8'h00, 8'h02, 8'h01, 0);
    idle(2); check_regs("post_reset_pkt");

    // Error counter saturation
    for (int i = 0; i < 300; i++) send_pkt(8'h01, 8'h00, 8'h00, 8'h55, 0);
    idle(2); check("err_cnt_sat", {56'd0, err_cnt}, 64'hFF);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      g = $urandom_range(0, 19);
      g = (g == 0) ? TMO - 1 : (g == 1) ? TMO : $urandom_range(0, 2);
      opc = 8'($urandom_range(1, 4)); phi = 8'($urandom); plo = 8'($urandom);
      if (r == 5) opc = 8'h0F;
      if (r == 7) opc = 8'($urandom);
      chk = opc ^ phi ^ plo;
      if (r == 6) chk = chk ^ 8'($urandom_range(1, 255));
      if (r == 8) begin
        send_byte(8'($urandom), g);
      end else if (r == 9) begin
        send_byte(8'hA5, 0);
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) send_byte(8'($urandom), 0);
        idle(TMO + $urandom_range(0, 3));
      end else begin
        send_pkt(opc, phi, plo, chk, g);
      end
    end
    idle(TMO + 3);
    check_regs("random_final");
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
